// File: rtl/spi_bus_arbiter_if.sv
// Bundle of request/grant, per-host SPI pins and shared bus pins for spi_bus_arbiter.
// The slave modport is the arbiter's view; master is the hosts/pads side.
interface spi_bus_arbiter_if #(
    parameter int NumReq = 2
);
    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] gnt_o;
    logic [NumReq-1:0] host_sclk_i;
    logic [NumReq-1:0] host_copi_i;
    logic [NumReq-1:0] host_cs_ni;
    logic [NumReq-1:0] host_cipo_o;
    logic              spi_sclk_o;
    logic              spi_copi_o;
    logic              spi_cs_no;
    logic              spi_en_o;
    logic              spi_cipo_i;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  req_i, host_sclk_i, host_copi_i, host_cs_ni, spi_cipo_i,
        output gnt_o, host_cipo_o, spi_sclk_o, spi_copi_o, spi_cs_no, spi_en_o,
               busy_o, timeout_o
    );

    modport master (
        output req_i, host_sclk_i, host_copi_i, host_cs_ni, spi_cipo_i,
        input  gnt_o, host_cipo_o, spi_sclk_o, spi_copi_o, spi_cs_no, spi_en_o,
               busy_o, timeout_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one shared SPI bus among NumReq hosts, with an idle guard gap between owners.
// Define SPI_ARB_TIMEOUT_EN to add forced revoke of an owner holding the bus for TimeoutCycles.
module spi_bus_arbiter #(
    parameter int NumReq        = 2,
    parameter int GuardCycles   = 2,
    parameter int TimeoutCycles = 4096
) (
    input logic              clk_sys_i,
    input logic              rst_sys_i,
    spi_bus_arbiter_if.slave bus
);
    localparam int         IdxW      = $clog2(NumReq);
    localparam logic [3:0] GuardLoad = (GuardCycles > 0) ? 4'(GuardCycles - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_e;

    state_e            state_q;
    logic [NumReq-1:0] gnt_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   owner_q;
    logic [IdxW-1:0]   owner_d;
    logic              found_d;
    logic [3:0]        guard_q;
    logic [NumReq-1:0] elig_req;
    logic              rel_d;
    int                cand;
    logic [IdxW-1:0]   cand_idx;

    logic              sclk_d;
    logic              copi_d;
    logic              cs_n_d;
    logic [NumReq-1:0] cipo_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int HoldW = ($clog2(TimeoutCycles + 1) > 12) ? $clog2(TimeoutCycles + 1) : 12;
    localparam logic [HoldW-1:0] HoldLimit = HoldW'(TimeoutCycles - 1);

    logic [HoldW-1:0]  hold_q;
    logic              timeout_q;
    logic [NumReq-1:0] revoked_q;
    logic              revoke_d;

    // A revoked host stays masked until it has dropped its request once.
    assign elig_req = bus.req_i & ~revoked_q;
    assign revoke_d = bus.req_i[owner_q] && (hold_q == HoldLimit);
    assign rel_d    = !bus.req_i[owner_q] || revoke_d;
    assign bus.timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign elig_req = bus.req_i;
    assign rel_d    = !bus.req_i[owner_q];
    assign bus.timeout_o = 1'b0;
`endif

    // First eligible requester strictly after the last owner, wrapping.
    always_comb begin
        owner_d  = ptr_q;
        found_d  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumReq) cand = cand - NumReq;
            cand_idx = IdxW'(cand);
            if (!found_d && elig_req[cand_idx]) begin
                owner_d = cand_idx;
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= IdxW'(NumReq - 1);
            owner_q <= '0;
            guard_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
            revoked_q <= '0;
`endif
        end else begin
`ifdef SPI_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            revoked_q <= revoked_q & bus.req_i;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        owner_q <= owner_d;
                        ptr_q   <= owner_d;
                        gnt_q   <= '0;
                        gnt_q[owner_d] <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                        hold_q <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (rel_d) begin
                        gnt_q   <= '0;
                        guard_q <= GuardLoad;
                        if (GuardCycles > 0) state_q <= GUARD;
                        else                 state_q <= IDLE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    if (revoke_d) begin
                        timeout_q          <= 1'b1;
                        revoked_q[owner_q] <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end
                GUARD: begin
                    if (guard_q == 4'd0) state_q <= IDLE;
                    else                 guard_q <= guard_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pins follow the owner only while granted; otherwise held at idle levels.
    always_comb begin
        sclk_d = 1'b0;
        copi_d = 1'b1;
        cs_n_d = 1'b1;
        cipo_d = '1;
        if (state_q == GRANT) begin
            sclk_d          = bus.host_sclk_i[owner_q];
            copi_d          = bus.host_copi_i[owner_q];
            cs_n_d          = bus.host_cs_ni[owner_q];
            cipo_d[owner_q] = bus.spi_cipo_i;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.spi_sclk_o  = sclk_d;
    assign bus.spi_copi_o  = copi_d;
    assign bus.spi_cs_no   = cs_n_d;
    assign bus.host_cipo_o = cipo_d;
    assign bus.spi_en_o    = 1'b1;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed-vector bench for spi_bus_arbiter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares. Instance u_dut uses GuardCycles=2, u_dut_g0 GuardCycles=0.
module tb_spi_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bit         sel = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] req       = 2'b00;
    logic [1:0] host_cs_n = 2'b11;
    logic [1:0] host_sclk = 2'b00;
    logic [1:0] host_copi = 2'b11;
    logic       cipo      = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];
    bit         sel_q[$];
    string      name_q[$];

    logic [9:0] act_a;
    logic [9:0] act_b;
    logic [9:0] m_exp;
    logic [9:0] m_act;
    bit         m_sel;
    string      m_name;

    always #5 clk = ~clk;

    // Only the instance under test sees rst; the other is parked in reset.
    assign rst_a = sel ? 1'b1 : rst;
    assign rst_b = sel ? rst : 1'b1;

    spi_bus_arbiter_if #(.NumReq(2)) bus_a ();
    spi_bus_arbiter_if #(.NumReq(2)) bus_b ();

    assign bus_a.req_i       = req;
    assign bus_a.host_sclk_i = host_sclk;
    assign bus_a.host_copi_i = host_copi;
    assign bus_a.host_cs_ni  = host_cs_n;
    assign bus_a.spi_cipo_i  = cipo;
    assign bus_b.req_i       = req;
    assign bus_b.host_sclk_i = host_sclk;
    assign bus_b.host_copi_i = host_copi;
    assign bus_b.host_cs_ni  = host_cs_n;
    assign bus_b.spi_cipo_i  = cipo;

    spi_bus_arbiter #(.NumReq(2), .GuardCycles(2), .TimeoutCycles(16)) u_dut (
        .clk_sys_i (clk),
        .rst_sys_i (rst_a),
        .bus       (bus_a)
    );

    spi_bus_arbiter #(.NumReq(2), .GuardCycles(0), .TimeoutCycles(16)) u_dut_g0 (
        .clk_sys_i (clk),
        .rst_sys_i (rst_b),
        .bus       (bus_b)
    );

    assign act_a = {bus_a.gnt_o, bus_a.spi_cs_no, bus_a.spi_sclk_o, bus_a.spi_copi_o,
                    bus_a.host_cipo_o, bus_a.busy_o, bus_a.timeout_o, bus_a.spi_en_o};
    assign act_b = {bus_b.gnt_o, bus_b.spi_cs_no, bus_b.spi_sclk_o, bus_b.spi_copi_o,
                    bus_b.host_cipo_o, bus_b.busy_o, bus_b.timeout_o, bus_b.spi_en_o};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_sel  = sel_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = m_sel ? act_b : act_a;
            vectors++;
            if (m_act !== m_exp) begin
                miscompares++;
                $display("FAIL %s: {gnt,cs_n,sclk,copi,hcipo,busy,to,en} got %b required %b",
                         m_name, m_act, m_exp);
            end
        end
    end

    task automatic vec(input string nm, input bit s, input bit r,
                       input logic [1:0] rq, input logic [1:0] csn, input logic [1:0] sck,
                       input logic [1:0] cp, input logic ci,
                       input logic [1:0] g, input logic cs, input logic sc, input logic co,
                       input logic [1:0] hc, input logic b, input logic t);
        sel       = s;
        rst       = r;
        req       = rq;
        host_cs_n = csn;
        host_sclk = sck;
        host_copi = cp;
        cipo      = ci;
        exp_q.push_back({g, cs, sc, co, hc, b, t, 1'b1});
        sel_q.push_back(s);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_v(input string nm, input bit s, input bit r, input logic [1:0] rq,
                          input logic [1:0] g, input logic b, input logic t);
        vec(nm, s, r, rq, 2'b11, 2'b00, 2'b11, 1'b1, g, 1'b1, 1'b0, 1'b1, 2'b11, b, t);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // GuardCycles=2 instance: tracking, round robin, guard gap, async reset
        idle_v("reset",            0, 1, 2'b00, 2'b00, 0, 0);
        idle_v("idle_after_reset", 0, 0, 2'b01, 2'b00, 0, 0);
        vec("grant_h0_track",      0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 1'b0, 2'b01, 0, 1, 0, 2'b10, 1, 0);
        vec("h0_track_2",          0, 0, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1, 2'b01, 0, 0, 1, 2'b11, 1, 0);
        vec("h0_cs_high",          0, 0, 2'b01, 2'b11, 2'b00, 2'b11, 1'b0, 2'b01, 1, 0, 1, 2'b10, 1, 0);
        idle_v("h0_drop_h1_raise", 0, 0, 2'b10, 2'b01, 1, 0);
        idle_v("guard1",           0, 0, 2'b10, 2'b00, 1, 0);
        idle_v("guard2",           0, 0, 2'b10, 2'b00, 1, 0);
        idle_v("guard_to_idle",    0, 0, 2'b10, 2'b00, 0, 0);
        vec("grant_h1_track",      0, 0, 2'b10, 2'b01, 2'b10, 2'b01, 1'b0, 2'b10, 0, 1, 0, 2'b01, 1, 0);
        vec("h1_ignores_h0",       0, 0, 2'b11, 2'b01, 2'b00, 2'b11, 1'b1, 2'b10, 0, 0, 1, 2'b11, 1, 0);
        vec("h1_release",          0, 0, 2'b01, 2'b11, 2'b00, 2'b11, 1'b0, 2'b10, 1, 0, 1, 2'b01, 1, 0);
        idle_v("guard_a1",         0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("guard_a2",         0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("idle_a",           0, 0, 2'b01, 2'b00, 0, 0);
        idle_v("rr_back_h0",       0, 0, 2'b00, 2'b01, 1, 0);
        idle_v("rereq_in_guard1",  0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("rereq_in_guard2",  0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("rereq_idle",       0, 0, 2'b01, 2'b00, 0, 0);
        idle_v("regrant_h0",       0, 0, 2'b00, 2'b01, 1, 0);
        idle_v("guard_b1",         0, 0, 2'b00, 2'b00, 1, 0);
        idle_v("guard_b2",         0, 0, 2'b00, 2'b00, 1, 0);
        idle_v("idle_b",           0, 0, 2'b01, 2'b00, 0, 0);
        vec("pre_reset_grant",     0, 0, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1, 2'b01, 0, 0, 1, 2'b11, 1, 0);
        vec("async_reset",         0, 1, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1, 2'b00, 1, 0, 1, 2'b11, 0, 0);
        idle_v("post_reset",       0, 0, 2'b00, 2'b00, 0, 0);

        // GuardCycles=0 instance: regrant one cycle after release, pointer wrap
        idle_v("g0_reset",         1, 1, 2'b00, 2'b00, 0, 0);
        idle_v("g0_idle",          1, 0, 2'b01, 2'b00, 0, 0);
        idle_v("g0_grant_h0",      1, 0, 2'b00, 2'b01, 1, 0);
        idle_v("g0_no_guard",      1, 0, 2'b01, 2'b00, 0, 0);
        idle_v("g0_regrant_h0",    1, 0, 2'b00, 2'b01, 1, 0);
        idle_v("g0_idle2",         1, 0, 2'b10, 2'b00, 0, 0);
        vec("g0_grant_h1",         1, 0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 2'b10, 1, 0, 1, 2'b01, 1, 0);
        idle_v("g0_idle3",         1, 0, 2'b11, 2'b00, 0, 0);
        idle_v("g0_rr_h0",         1, 0, 2'b10, 2'b01, 1, 0);
        idle_v("g0_idle4",         1, 0, 2'b10, 2'b00, 0, 0);
        idle_v("g0_grant_h1b",     1, 0, 2'b00, 2'b10, 1, 0);
        idle_v("g0_idle5",         1, 0, 2'b00, 2'b00, 0, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        // TimeoutCycles=16: revoke after 16 granted cycles, revoked host masked until it drops req
        idle_v("to_reset",         0, 1, 2'b00, 2'b00, 0, 0);
        idle_v("to_idle",          0, 0, 2'b01, 2'b00, 0, 0);
        for (int k = 0; k < 16; k++) begin
            idle_v("to_hold",      0, 0, 2'b01, 2'b01, 1, 0);
        end
        idle_v("to_revoke",        0, 0, 2'b11, 2'b00, 1, 1);
        idle_v("to_guard",         0, 0, 2'b11, 2'b00, 1, 0);
        idle_v("to_idle_h1",       0, 0, 2'b11, 2'b00, 0, 0);
        idle_v("to_grant_h1",      0, 0, 2'b01, 2'b10, 1, 0);
        idle_v("to_guard_c1",      0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("to_guard_c2",      0, 0, 2'b01, 2'b00, 1, 0);
        idle_v("to_h0_masked",     0, 0, 2'b00, 2'b00, 0, 0);
        idle_v("to_h0_still_out",  0, 0, 2'b00, 2'b00, 0, 0);
        idle_v("to_h0_rereq",      0, 0, 2'b01, 2'b00, 0, 0);
        idle_v("to_regrant_h0",    0, 0, 2'b00, 2'b01, 1, 0);
        idle_v("to_guard_d",       0, 0, 2'b00, 2'b00, 1, 0);
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
